regfile_write_arbiter: RTL and testbench

//  Shares the single write port (LD/DR/D_in) of the 8x8 register file between two producers.

---
 rtl/regfile_write_arbiter_pkg.sv | 14 +
 rtl/regfile_write_arbiter_if.sv | 32 +++
 rtl/regfile_write_arbiter_wr_slot.sv | 32 +++
 rtl/regfile_write_arbiter.sv | 95 +++++++++
 tb/tb_regfile_write_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants and the port-owner type used by the
// write arbiter and its slots.
package regfile_pkg;
  localparam int unsigned REG_DATA_W = 8;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned NUM_REGS   = 8;
  localparam logic        PORT_A     = 1'b0;
  localparam logic        PORT_B     = 1'b1;

  typedef enum logic {
    OWNER_A = PORT_A,
    OWNER_B = PORT_B
  } port_e;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Producer handshakes, register-file write port and scoreboard of the
// write arbiter.
interface regfile_write_arbiter_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
);
  logic                   A_VALID;
  logic                   A_READY;
  logic [ADDR_W-1:0]      A_DR;
  logic [DATA_W-1:0]      A_DATA;
  logic                   B_VALID;
  logic                   B_READY;
  logic [ADDR_W-1:0]      B_DR;
  logic [DATA_W-1:0]      B_DATA;
  logic                   LD;
  logic [ADDR_W-1:0]      DR;
  logic [DATA_W-1:0]      D_OUT;
  logic [2**ADDR_W-1:0]   PEND;
  logic                   BUSY;

  modport master (
    output A_VALID, A_DR, A_DATA, B_VALID, B_DR, B_DATA,
    input  A_READY, B_READY, LD, DR, D_OUT, PEND, BUSY
  );

  modport slave (
    input  A_VALID, A_DR, A_DATA, B_VALID, B_DR, B_DATA,
    output A_READY, B_READY, LD, DR, D_OUT, PEND, BUSY
  );
endinterface

// File: rtl/regfile_write_arbiter_wr_slot.sv
// One-entry holding buffer for a pending register write; a load on the
// draining edge refills the slot.
module wr_slot
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              load,
  input  logic              drain,
  input  logic [ADDR_W-1:0] load_dr,
  input  logic [DATA_W-1:0] load_data,
  output logic              full,
  output logic [ADDR_W-1:0] dr,
  output logic [DATA_W-1:0] data
);
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      full <= 1'b0;
      dr   <= '0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      dr   <= load_dr;
      data <= load_data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between ALU (A) and load (B)
// writeback, with per-register ordering and a pending-write scoreboard.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter bit          FAIR   = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  regfile_write_arbiter_if.slave   bus
);
  localparam int unsigned NREG = 2**ADDR_W;

  logic              full_a, full_b;
  logic [ADDR_W-1:0] dr_a, dr_b;
  logic [DATA_W-1:0] data_a, data_b;
  logic              grant_a, grant_b;
  logic              load_a, load_b;
  logic [NREG-1:0]   pend;
  port_e             age;
  port_e             last_grant;

  assign bus.A_READY = ~full_a | grant_a;
  assign bus.B_READY = ~full_b | grant_b;
  assign load_a      = bus.A_VALID & bus.A_READY;
  assign load_b      = bus.B_VALID & bus.B_READY;

  wr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
    .CLK(CLK), .RESET_N(RESET_N), .load(load_a), .drain(grant_a),
    .load_dr(bus.A_DR), .load_data(bus.A_DATA),
    .full(full_a), .dr(dr_a), .data(data_a)
  );

  wr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
    .CLK(CLK), .RESET_N(RESET_N), .load(load_b), .drain(grant_b),
    .load_dr(bus.B_DR), .load_data(bus.B_DATA),
    .full(full_b), .dr(dr_b), .data(data_b)
  );

  // Grant depends only on slot state, so READY never loops back through VALID.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case ({full_a, full_b})
      2'b10: grant_a = 1'b1;
      2'b01: grant_b = 1'b1;
      2'b11: begin
        if (dr_a == dr_b)  grant_a = (age == OWNER_A);
        else if (FAIR)     grant_a = (last_grant == OWNER_B);
        else               grant_a = 1'b1;
        grant_b = ~grant_a;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.LD    = grant_a | grant_b;
    bus.DR    = '0;
    bus.D_OUT = '0;
    if (grant_a) begin
      bus.DR    = dr_a;
      bus.D_OUT = data_a;
    end else if (grant_b) begin
      bus.DR    = dr_b;
      bus.D_OUT = data_b;
    end
  end

  always_comb begin
    pend = '0;
    if (full_a) pend[dr_a] = 1'b1;
    if (full_b) pend[dr_b] = 1'b1;
  end

  assign bus.PEND = pend;
  assign bus.BUSY = full_a | full_b;

  // A newly loaded slot is younger than a partner that is still waiting.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      age        <= OWNER_A;
      last_grant <= OWNER_B;
    end else begin
      if (load_a && load_b)                 age <= OWNER_A;
      else if (load_a && full_b && !grant_b) age <= OWNER_B;
      else if (load_b && full_a && !grant_a) age <= OWNER_A;

      if (grant_a)      last_grant <= OWNER_A;
      else if (grant_b) last_grant <= OWNER_B;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: a round-robin and a fixed-priority
// instance share stimulus and are checked against a request-age model.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic       CLK;
  logic       RESET_N;
  logic       a_valid, b_valid;
  logic [2:0] a_dr, b_dr;
  logic [7:0] a_data, b_data;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_write_arbiter_if #(.DATA_W(8), .ADDR_W(3)) if_fr ();
  regfile_write_arbiter_if #(.DATA_W(8), .ADDR_W(3)) if_fp ();

  assign if_fr.A_VALID = a_valid;  assign if_fp.A_VALID = a_valid;
  assign if_fr.A_DR    = a_dr;     assign if_fp.A_DR    = a_dr;
  assign if_fr.A_DATA  = a_data;   assign if_fp.A_DATA  = a_data;
  assign if_fr.B_VALID = b_valid;  assign if_fp.B_VALID = b_valid;
  assign if_fr.B_DR    = b_dr;     assign if_fp.B_DR    = b_dr;
  assign if_fr.B_DATA  = b_data;   assign if_fp.B_DATA  = b_data;

  regfile_write_arbiter #(.DATA_W(8), .ADDR_W(3), .FAIR(1'b1)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(if_fr.slave)
  );
  regfile_write_arbiter #(.DATA_W(8), .ADDR_W(3), .FAIR(1'b0)) u_dut_fp (
    .CLK(CLK), .RESET_N(RESET_N), .bus(if_fp.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file as seen through the round-robin instance's write port.
  logic [7:0] obs_mem [NUM_REGS];
  always @(posedge CLK) if (if_fr.LD) obs_mem[if_fr.DR] <= if_fr.D_OUT;

  // Model: each port holds at most one request stamped with its arrival order.
  bit         m_full [2][2];
  logic [2:0] m_dr   [2][2];
  logic [7:0] m_data [2][2];
  int         m_seq  [2][2];
  int         m_last [2];
  int         m_ctr  [2];

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) m_full[i][p] = 1'b0;
      m_last[i] = 1;
      m_ctr[i]  = 0;
    end
  endfunction

  function automatic int m_grant(int i);
    if (!m_full[i][0] && !m_full[i][1]) return -1;
    if (!m_full[i][1]) return 0;
    if (!m_full[i][0]) return 1;
    if (m_dr[i][0] == m_dr[i][1]) return (m_seq[i][0] < m_seq[i][1]) ? 0 : 1;
    if (i == 0) return 1 - m_last[i];
    return 0;
  endfunction

  function automatic bit m_ready(int i, int p);
    return !m_full[i][p] || (m_grant(i) == p);
  endfunction

  function automatic void m_step();
    for (int i = 0; i < 2; i++) begin
      int g;
      bit ra, rb;
      g  = m_grant(i);
      ra = m_ready(i, 0);
      rb = m_ready(i, 1);
      if (g >= 0) begin
        m_full[i][g] = 1'b0;
        m_last[i]    = g;
      end
      if (a_valid && ra) begin
        m_full[i][0] = 1'b1; m_dr[i][0] = a_dr; m_data[i][0] = a_data;
        m_seq[i][0]  = m_ctr[i]; m_ctr[i]++;
      end
      if (b_valid && rb) begin
        m_full[i][1] = 1'b1; m_dr[i][1] = b_dr; m_data[i][1] = b_data;
        m_seq[i][1]  = m_ctr[i]; m_ctr[i]++;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_check();
    for (int i = 0; i < 2; i++) begin
      int         g;
      logic [7:0] ep;
      logic       ld, ra, rb, busy;
      logic [2:0] dr;
      logic [7:0] d, pend;
      g  = m_grant(i);
      ep = '0;
      for (int p = 0; p < 2; p++) if (m_full[i][p]) ep[m_dr[i][p]] = 1'b1;
      if (i == 0) begin
        ld = if_fr.LD; dr = if_fr.DR; d = if_fr.D_OUT; ra = if_fr.A_READY;
        rb = if_fr.B_READY; pend = if_fr.PEND; busy = if_fr.BUSY;
      end else begin
        ld = if_fp.LD; dr = if_fp.DR; d = if_fp.D_OUT; ra = if_fp.A_READY;
        rb = if_fp.B_READY; pend = if_fp.PEND; busy = if_fp.BUSY;
      end
      chk($sformatf("model%0d.LD", i),    32'(ld),   32'(g >= 0));
      chk($sformatf("model%0d.DR", i),    32'(dr),   (g >= 0) ? 32'(m_dr[i][g])   : 32'd0);
      chk($sformatf("model%0d.D_OUT", i), 32'(d),    (g >= 0) ? 32'(m_data[i][g]) : 32'd0);
      chk($sformatf("model%0d.A_READY", i), 32'(ra), 32'(m_ready(i, 0)));
      chk($sformatf("model%0d.B_READY", i), 32'(rb), 32'(m_ready(i, 1)));
      chk($sformatf("model%0d.PEND", i),  32'(pend), 32'(ep));
      chk($sformatf("model%0d.BUSY", i),  32'(busy), 32'(m_full[i][0] | m_full[i][1]));
    end
  endtask

  // Called at the falling edge; checks, then advances past the next rising edge.
  task automatic tick();
    m_check();
    @(posedge CLK);
    m_step();
    #1;
  endtask

  task automatic set_in(input int av, input int adr, input int ad,
                        input int bv, input int bdr, input int bd);
    a_valid = (av != 0); a_dr = 3'(adr); a_data = 8'(ad);
    b_valid = (bv != 0); b_dr = 3'(bdr); b_data = 8'(bd);
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    RESET_N = 1'b0;
    m_reset();
    @(posedge CLK);
    #1 RESET_N = 1'b1;
  endtask

  // Mid-cycle asynchronous reset with both instances' state discarded.
  task automatic async_reset(input string tag);
    set_in(0, 0, 0, 0, 0, 0);
    #2 RESET_N = 1'b0;
    #1;
    m_reset();
    chk({tag, ".fr.LD"},   32'(if_fr.LD),   32'd0);
    chk({tag, ".fr.PEND"}, 32'(if_fr.PEND), 32'd0);
    chk({tag, ".fr.BUSY"}, 32'(if_fr.BUSY), 32'd0);
    chk({tag, ".fp.LD"},   32'(if_fp.LD),   32'd0);
    chk({tag, ".fp.PEND"}, 32'(if_fp.PEND), 32'd0);
    chk({tag, ".fp.BUSY"}, 32'(if_fp.BUSY), 32'd0);
    @(posedge CLK);
    #1 RESET_N = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    bit         av;  logic [2:0] adr; logic [7:0] ad;
    bit         bv;  logic [2:0] bdr; logic [7:0] bd;
    bit         ld;  logic [2:0] dr;  logic [7:0] dout;
    bit         ardy; bit brdy;
  } vec_t;

  function automatic vec_t mk(int rst, int av, int adr, int ad, int bv, int bdr, int bd,
                              int ld, int dr, int dout, int ardy, int brdy);
    vec_t v;
    v.rst = (rst != 0); v.av = (av != 0); v.adr = 3'(adr); v.ad = 8'(ad);
    v.bv = (bv != 0); v.bdr = 3'(bdr); v.bd = 8'(bd);
    v.ld = (ld != 0); v.dr = 3'(dr); v.dout = 8'(dout);
    v.ardy = (ardy != 0); v.brdy = (brdy != 0);
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc_a, acc_b;
    // single port A back-to-back
    vecs.push_back(mk(1, 1,3,'h5A, 0,0,0,    0,0,0,     1,1));
    vecs.push_back(mk(0, 1,4,'hA5, 0,0,0,    1,3,'h5A,  1,1));
    vecs.push_back(mk(0, 0,0,0,    0,0,0,    1,4,'hA5,  1,1));
    vecs.push_back(mk(0, 0,0,0,    0,0,0,    0,0,0,     1,1));
    // round-robin streaming, producers hold until accepted
    vecs.push_back(mk(1, 1,0,'h10, 1,4,'h20, 0,0,0,     1,1));
    vecs.push_back(mk(0, 1,1,'h11, 1,4,'h20, 1,0,'h10,  1,0));
    vecs.push_back(mk(0, 1,1,'h11, 1,5,'h21, 1,4,'h20,  0,1));
    vecs.push_back(mk(0, 1,2,'h12, 1,5,'h21, 1,1,'h11,  1,0));
    vecs.push_back(mk(0, 1,2,'h12, 1,6,'h22, 1,5,'h21,  0,1));
    vecs.push_back(mk(0, 1,3,'h13, 1,6,'h22, 1,2,'h12,  1,0));
    vecs.push_back(mk(0, 0,0,0,    0,0,0,    1,6,'h22,  0,1));
    vecs.push_back(mk(0, 0,0,0,    0,0,0,    1,3,'h13,  1,1));
    vecs.push_back(mk(0, 0,0,0,    0,0,0,    0,0,0,     1,1));
    // same-register ordering: older B write goes out before younger A
    vecs.push_back(mk(1, 1,5,'h33, 1,2,'h11, 0,0,0,     1,1));
    vecs.push_back(mk(0, 1,2,'h22, 0,0,0,    1,5,'h33,  1,0));
    vecs.push_back(mk(0, 0,0,0,    0,0,0,    1,2,'h11,  0,1));
    vecs.push_back(mk(0, 0,0,0,    0,0,0,    1,2,'h22,  1,1));
    vecs.push_back(mk(0, 0,0,0,    0,0,0,    0,0,0,     1,1));

    set_in(0, 0, 0, 0, 0, 0);
    RESET_N = 1'b1;
    #1 RESET_N = 1'b0;
    m_reset();
    #1;
    chk("reset.LD",    32'(if_fr.LD),    32'd0);
    chk("reset.DR",    32'(if_fr.DR),    32'd0);
    chk("reset.D_OUT", 32'(if_fr.D_OUT), 32'd0);
    chk("reset.PEND",  32'(if_fr.PEND),  32'd0);
    chk("reset.BUSY",  32'(if_fr.BUSY),  32'd0);
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    @(negedge CLK);
    chk("reset.A_READY", 32'(if_fr.A_READY), 32'd1);
    chk("reset.B_READY", 32'(if_fr.B_READY), 32'd1);
    tick();

    // reset with both slots full
    set_in(1, 1, 'h01, 1, 6, 'h06);
    @(negedge CLK);
    tick();
    chk("midrst.pre.BUSY", 32'(if_fr.BUSY), 32'd1);
    async_reset("midrst");
    @(negedge CLK);
    chk("midrst.post.A_READY", 32'(if_fr.A_READY), 32'd1);
    chk("midrst.post.B_READY", 32'(if_fr.B_READY), 32'd1);
    tick();

    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      a_valid = vecs[k].av; a_dr = vecs[k].adr; a_data = vecs[k].ad;
      b_valid = vecs[k].bv; b_dr = vecs[k].bdr; b_data = vecs[k].bd;
      @(negedge CLK);
      chk($sformatf("vec%0d.LD", k),      32'(if_fr.LD),      32'(vecs[k].ld));
      chk($sformatf("vec%0d.DR", k),      32'(if_fr.DR),      32'(vecs[k].dr));
      chk($sformatf("vec%0d.D_OUT", k),   32'(if_fr.D_OUT),   32'(vecs[k].dout));
      chk($sformatf("vec%0d.A_READY", k), 32'(if_fr.A_READY), 32'(vecs[k].ardy));
      chk($sformatf("vec%0d.B_READY", k), 32'(if_fr.B_READY), 32'(vecs[k].brdy));
      tick();
    end
    chk("order.R2_final", 32'(obs_mem[2]), 32'h22);

    // scoreboard: A holds R7, B holds R1
    do_reset();
    set_in(1, 7, 'h77, 1, 1, 'h01);
    @(negedge CLK); tick();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("pend.both",      32'(if_fr.PEND), 32'h82);
    chk("pend.both.BUSY", 32'(if_fr.BUSY), 32'd1);
    tick();
    @(negedge CLK); tick();
    @(negedge CLK);
    chk("pend.drained",      32'(if_fr.PEND), 32'h00);
    chk("pend.drained.BUSY", 32'(if_fr.BUSY), 32'd0);
    tick();

    // fixed priority: A wins while it keeps streaming, B waits
    do_reset();
    set_in(1, 0, 'hA0, 1, 7, 'hB7);
    @(negedge CLK); tick();
    for (int c = 1; c <= 4; c++) begin
      set_in(1, c, 'hA0 + c, 1, 6, 'hB6);
      @(negedge CLK);
      chk($sformatf("fp.c%0d.LD", c),      32'(if_fp.LD),      32'd1);
      chk($sformatf("fp.c%0d.DR", c),      32'(if_fp.DR),      32'(c - 1));
      chk($sformatf("fp.c%0d.B_READY", c), 32'(if_fp.B_READY), 32'd0);
      tick();
    end
    set_in(0, 0, 0, 1, 6, 'hB6);
    @(negedge CLK);
    chk("fp.c5.DR",      32'(if_fp.DR),      32'd4);
    chk("fp.c5.B_READY", 32'(if_fp.B_READY), 32'd0);
    tick();
    @(negedge CLK);
    chk("fp.c6.DR",      32'(if_fp.DR),      32'd7);
    chk("fp.c6.B_READY", 32'(if_fp.B_READY), 32'd1);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge CLK); tick();
    @(negedge CLK); tick();

    // randomized traffic, narrow register range to provoke same-DR conflicts
    do_reset();
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      acc_a = a_valid && m_ready(0, 0);
      acc_b = b_valid && m_ready(0, 1);
      tick();
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_rst");
        continue;
      end
      if (!(a_valid && !acc_a && $urandom_range(0, 7) != 0)) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_dr    = 3'($urandom_range(0, 3));
        a_data  = 8'($urandom);
      end
      if (!(b_valid && !acc_b && $urandom_range(0, 7) != 0)) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_dr    = 3'($urandom_range(0, 3));
        b_data  = 8'($urandom);
      end
    end
    set_in(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) begin
      @(negedge CLK); tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
